ma_inverse: RTL and testbench
=============================

Name: ma_inverse

Overview:
- Inverse of the team's moving-sum/moving-average stage: recovers the original sample stream x[n] from a window-N running sum y[n] = x[n] + x[n-1] + ... + x[n-N+1].
- Recursion: x[n] = y[n] - y[n-1] + x[n-N].
- Sits downstream of the moving-average block in loopback/verification chains and decodes its output back to raw samples.
- Fixed-point signed integers (synthesizable), with valid/ready handshakes on both sides.

Parameters:
- WIN_LEN, 3: window length N (>= 2).
- DATA_W, 16: signed width of recovered sample x.
- SUM_W, DATA_W+$clog2(WIN_LEN)+1: signed width of the input running sum y.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  global enable; when 0, all state, including the FSM, holds.
- clr  in  1  synchronous clear of history; takes priority over the handshake when en=1.
- in_valid  in  1  input sum valid.
- in_data  in  SUM_W  signed running sum y[n].
- in_ready  out  1  block can accept in_data.
- out_valid  out  1  recovered sample valid.
- out_data  out  DATA_W  signed recovered x[n].
- out_ready  in  1  downstream accepts out_data.
- ovf  out  1  sticky flag: a recovered value did not fit in DATA_W.

Behaviour:
- Reset (rst=0, async):
  - state=ST_IN.
  - in_ready=1, out_valid=0, out_data=0, ovf=0.
  - y_prev=0; history shift register (WIN_LEN x DATA_W) all 0.
  - This matches a moving-sum upstream that starts from zeros.
- FSM, 3 states, advancing only when en=1:
  - ST_IN: in_ready=1. On in_valid: latch y_cur<=in_data and go to ST_CALC.
  - ST_CALC: in_ready=0.
    - Compute d = y_cur - y_prev + sign-extend(hist[WIN_LEN-1]) at SUM_W+1 bits.
    - out_data <= d[DATA_W-1:0]; out_valid <= 1.
    - If d is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1], set ovf=1 (sticky until reset or clr).
    - y_prev <= y_cur.
    - Shift history: hist[k] <= hist[k-1]; hist[0] <= d[DATA_W-1:0].
    - Go to ST_OUT.
  - ST_OUT: in_ready=0, out_valid=1. out_data is held stable while out_ready=0. When out_ready=1: out_valid <= 0, go to ST_IN.
- Latency and throughput:
  - Accept at edge k; out_valid high from edge k+1.
  - Peak throughput is one sample per 3 cycles when out_ready is held high.
- History indexing: hist[WIN_LEN-1] is x[n-N] at the time of ST_CALC for sample n.
- en=0 in any state: no register changes, outputs hold. A pending out_valid stays high, but an out_ready pulse is ignored.
- clr=1 with en=1, any state:
  - Next cycle: y_prev=0, history=0, ovf=0, out_valid=0, state=ST_IN.
  - The in-flight sample is dropped.
  - clr wins over a simultaneous in_valid or out_ready.
- Arithmetic wraps modulo 2^DATA_W on out_data. ovf only reports the wrap; it does not saturate, so the history stays bit-consistent with a wrapping upstream.
- Reset asserted mid-operation (any state) returns immediately to the reset values above. No partial output remains visible.
- in_data is sampled only in ST_IN with in_valid=1. in_valid in other states is ignored; upstream must hold it until in_ready.

Test Plan:
- Basic decode (N=3, DATA_W=16): y = 5, 3, 10, 6, out_ready=1 -> out_data = 5, -2, 7, 1. Each out_valid is 1 cycle after acceptance, and in_ready has a 3-cycle period.
- Backpressure: same stream with out_ready=0 for 4 cycles after the first out_valid -> out_data holds at 5, in_ready=0 throughout, then sequence completes as -2, 7, 1 with no loss.
- Overflow: y = 32767, 32768 -> second out_data = 0x0001 (the 1-bit positive step wraps cleanly, ovf stays 0). Then y = -40000 -> d = -72768 + hist term, out_data = low 16 bits of d, ovf=1 and remains 1 for later samples.
- Clear: after y = 5, 3, pulse clr in ST_OUT together with out_ready=1 -> out_valid=0 next cycle, ovf=0. A new y = 4 then yields out_data = 4.
- Enable gating: en=0 for 5 cycles while in ST_CALC -> out_valid stays 0 and state is unchanged. After en=1, out_data is correct, and the result matches the en=1 run.
- Async reset mid-stream: drive rst=0 between clock edges while in ST_OUT -> out_valid=0, in_ready=1 immediately. After release, y = 9 yields out_data = 9 (history cleared).

Source files
------------

// File: rtl/ma_inverse.sv
// ma_inverse: recovers samples x[n] from a window-N running sum via x[n] = y[n] - y[n-1] + x[n-N]
module ma_inverse #(
  parameter int WIN_LEN = 3,
  parameter int DATA_W  = 16,
  parameter int SUM_W   = DATA_W + $clog2(WIN_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [SUM_W-1:0]  in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     ovf
);
  typedef enum logic [1:0] {ST_IN, ST_CALC, ST_OUT} state_t;
  state_t                    r_state;
  logic signed [SUM_W-1:0]   r_y_cur;
  logic signed [SUM_W-1:0]   r_y_prev;
  logic signed [DATA_W-1:0]  r_hist [WIN_LEN];
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_data;
  logic                      r_ovf;
  logic signed [SUM_W:0]     w_d;
  logic [SUM_W-DATA_W+1:0]   w_top;
  logic                      w_fit;
  // one guard bit above the sum width keeps the difference exact before the DATA_W wrap
  assign w_d      = (SUM_W+1)'(r_y_cur) - (SUM_W+1)'(r_y_prev) + (SUM_W+1)'(r_hist[WIN_LEN-1]);
  assign w_top    = w_d[SUM_W:DATA_W-1];
  assign w_fit    = (&w_top) | ~(|w_top);
  assign in_ready = (r_state == ST_IN);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ovf       = r_ovf;
  // handshake FSM plus decode datapath; history holds wrapped samples so it tracks a wrapping upstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IN;
      r_y_cur     <= '0;
      r_y_prev    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
      for (int k = 0; k < WIN_LEN; k++) r_hist[k] <= '0;
    end else if (en) begin
      if (clr) begin
        r_state     <= ST_IN;
        r_y_prev    <= '0;
        r_out_valid <= 1'b0;
        r_ovf       <= 1'b0;
        for (int k = 0; k < WIN_LEN; k++) r_hist[k] <= '0;
      end else begin
        case (r_state)
          ST_IN: if (in_valid) begin
            r_y_cur <= in_data;
            r_state <= ST_CALC;
          end
          ST_CALC: begin
            r_out_data  <= w_d[DATA_W-1:0];
            r_out_valid <= 1'b1;
            r_ovf       <= r_ovf | ~w_fit;
            r_y_prev    <= r_y_cur;
            for (int k = 1; k < WIN_LEN; k++) r_hist[k] <= r_hist[k-1];
            r_hist[0]   <= w_d[DATA_W-1:0];
            r_state     <= ST_OUT;
          end
          ST_OUT: if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IN;
          end
          default: r_state <= ST_IN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ma_inverse.sv
// tb_ma_inverse: directed and randomized checks of ma_inverse against a window-sum reference model
module tb_ma_inverse;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int SW = DW + $clog2(N) + 1;
  logic clk = 1'b0, rst = 1'b0, en = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [SW-1:0] in_data = '0;
  logic in_ready, out_valid, ovf;
  logic signed [DW-1:0] out_data;
  int n_chk = 0, n_pass = 0;
  int mq[$];
  int myp;
  bit movf;
  int last_dut;

  ma_inverse #(.WIN_LEN(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq = {0, 0, 0};
    myp = 0;
    movf = 0;
  endtask

  // x[n] is whatever makes the last N recovered samples add up to y[n] (mod 2^DW);
  // ovf follows the recursion value before wrapping
  task automatic model_step(input int y, output int e);
    int s, d;
    s = 0;
    for (int i = 1; i < N; i++) s += mq[i];
    e = int'(shortint'(y - s));
    d = y - myp + mq[0];
    if (d > 32767 || d < -32768) movf = 1;
    void'(mq.pop_front());
    mq.push_back(e);
    myp = y;
  endtask

  task automatic xfer(input int y, input int hold, input int gap, input bit clr_out);
    int e;
    check("rdy_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data = SW'(y);
    @(negedge clk);
    in_valid = 1'b0;
    check("rdy_busy", in_ready, 0);
    check("calc_no_valid", out_valid, 0);
    if (gap > 0) begin
      en = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        check("gap_valid", out_valid, 0);
        check("gap_rdy", in_ready, 0);
      end
      en = 1'b1;
    end
    @(negedge clk);
    model_step(y, e);
    last_dut = $signed(out_data);
    check("out_valid", out_valid, 1);
    check("out_data", $signed(out_data), e);
    check("ovf", ovf, movf);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", $signed(out_data), e);
      check("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    clr = clr_out;
    @(negedge clk);
    out_ready = 1'b0;
    clr = 1'b0;
    check("done_valid", out_valid, 0);
    check("done_rdy", in_ready, 1);
    if (clr_out) begin
      model_clear();
      check("clr_ovf", ovf, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    int xr, yv;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_rdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;
    @(negedge clk);
    xfer(5, 0, 0, 0);  check("basic0", last_dut, 5);
    xfer(3, 0, 0, 0);  check("basic1", last_dut, -2);
    xfer(10, 0, 0, 0); check("basic2", last_dut, 7);
    xfer(6, 0, 0, 0);  check("basic3", last_dut, 1);
    do_reset();
    xfer(5, 4, 0, 0);  check("bp0", last_dut, 5);
    xfer(3, 0, 0, 0);  check("bp1", last_dut, -2);
    xfer(10, 0, 0, 0); check("bp2", last_dut, 7);
    xfer(6, 0, 0, 0);  check("bp3", last_dut, 1);
    do_reset();
    xfer(32767, 0, 0, 0);  check("ovf_a", last_dut, 32767);
    xfer(32768, 0, 0, 0);  check("ovf_b", last_dut, 1);
    check("ovf_b_flag", ovf, 0);
    xfer(-40000, 0, 0, 0); check("ovf_c", last_dut, -7232);
    check("ovf_c_flag", ovf, 1);
    xfer(-39999, 0, 0, 0);
    check("ovf_sticky", ovf, 1);
    xfer(5, 0, 0, 0);
    xfer(3, 0, 0, 1);
    xfer(4, 0, 0, 0);  check("clr_new", last_dut, 4);
    do_reset();
    xfer(5, 0, 5, 0);  check("en_gate0", last_dut, 5);
    xfer(3, 2, 3, 0);  check("en_gate1", last_dut, -2);
    in_valid = 1'b1;
    in_data = SW'(7);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_rdy", in_ready, 1);
    check("arst_data", $signed(out_data), 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    xfer(9, 0, 0, 0);  check("arst_new", last_dut, 9);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      xr = int'($urandom_range(0, 65535)) - 32768;
      yv = xr + mq[1] + mq[2];
      xfer(yv, int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0) ? 2 : 0, 1'b0);
      check("rand_x", last_dut, xr);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
